// File: rtl/rv_alu.sv
// Registered RISC-V execute-stage integer ALU: one accepted operation per cycle,
// result, zero flag and illegal-opcode flag appear one clock after acceptance.
module rv_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             illegal_op
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  function automatic logic lt_signed(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b);
    return a < b;
  endfunction

  function automatic logic lt_unsigned(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    return a < b;
  endfunction

  logic signed [WIDTH-1:0] op1_s;
  logic        [SHW-1:0]   shamt;
  logic        [WIDTH-1:0] result_d, result_q;
  logic                    illegal_d, illegal_q;
  logic                    zero_q, vld_q;

  assign op1_s = op1;
  assign shamt = op2[SHW-1:0];

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    case (alu_op)
      OP_AND:  result_d = op1 & op2;
      OP_OR:   result_d = op1 | op2;
      OP_XOR:  result_d = op1 ^ op2;
      OP_ADD:  result_d = op1 + op2;
      OP_SUB:  result_d = op1 - op2;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_signed(op1, op2)};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_unsigned(op1, op2)};
      OP_SRL:  result_d = op1 >> shamt;
      OP_SLL:  result_d = op1 << shamt;
      OP_SRA:  result_d = op1_s >>> shamt;
      default: illegal_d = 1'b1;
    endcase
  end

  // Execute register stage: outputs hold until the next accepted operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        result_q  <= result_d;
        zero_q    <= (result_d == '0);
        illegal_q <= illegal_d;
      end
    end
  end

  assign result     = result_q;
  assign zero       = zero_q;
  assign out_valid  = vld_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_rv_alu.sv
// Directed bench for rv_alu: expected results are queued when an operation is
// driven and compared when out_valid appears.
module tb_rv_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] op1, op2;
  logic [3:0]  alu_op;
  logic [31:0] result;
  logic        zero, out_valid, illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  rv_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op1(op1), .op2(op2),
    .alu_op(alu_op), .result(result), .zero(zero), .out_valid(out_valid),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each out_valid pulse retires the oldest queued expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out_valid: got result %h with empty queue", result);
      end else begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_result"}, result, e.res);
        chk({t, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        chk({t, "_illegal"}, {31'd0, illegal_op}, {31'd0, e.ill});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic eil,
                       input string tag);
    in_valid = 1'b1;
    alu_op   = op;
    op1      = a;
    op2      = b;
    exp_q.push_back('{res: er, z: ez, ill: eil});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    alu_op   = 4'b0010;
    op1      = 32'hDEAD_BEEF;
    op2      = 32'h1234_5678;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles while a valid ADD is presented
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 4'b0010;
    op1      = 32'd20;
    op2      = 32'd22;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
    rst_n = 1'b1;

    issue(4'b0010, 32'd20, 32'd22, 32'h0000_002A, 1'b0, 1'b0, "add_20_22");
    issue(4'b0000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1, 1'b0, "and_a5_5a");
    issue(4'b0001, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0, "or_a5_5a");
    issue(4'b0101, 32'h1234_5678, 32'h8765_4321, 32'h9551_1559, 1'b0, 1'b0, "xor");
    issue(4'b0110, 32'd50, 32'd30, 32'h0000_0014, 1'b0, 1'b0, "sub_50_30");
    issue(4'b0110, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b0, "sub_5_5");
    issue(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_wrap");
    issue(4'b0100, 32'd10, 32'd20, 32'h0000_0001, 1'b0, 1'b0, "slt_10_20");
    issue(4'b0100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "slt_min_max");
    issue(4'b0100, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, "slt_max_min");
    issue(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "sltu_min_max");
    issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "sltu_max_min");
    issue(4'b0100, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0000, 1'b1, 1'b0, "slt_equal");
    issue(4'b0111, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b0, "sltu_equal");
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, "add_overflow");
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, "add_carry");
    issue(4'b1000, 32'hFFFF_FFFF, 32'd4, 32'h0FFF_FFFF, 1'b0, 1'b0, "srl_4");
    issue(4'b1001, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFF0, 1'b0, 1'b0, "sll_4");
    issue(4'b1010, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, "sra_4");
    issue(4'b1010, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0, "sra_shamt_mask");
    issue(4'b1010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, "sra_31");
    issue(4'b1000, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, "srl_31");
    issue(4'b1001, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b0, "sll_0");
    issue(4'b1001, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0, "sll_31");
    issue(4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b1, "illegal_1111");
    issue(4'b0001, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b0, "or_after_illegal");
    issue(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, "illegal_0011");

    // Three back-to-back ops, then idle: outputs must hold the last result
    issue(4'b0010, 32'd1, 32'd2, 32'h0000_0003, 1'b0, 1'b0, "b2b_1");
    issue(4'b0110, 32'd100, 32'd1, 32'h0000_0063, 1'b0, 1'b0, "b2b_2");
    issue(4'b0101, 32'hFFFF_0000, 32'h00FF_FF00, 32'hFF00_FF00, 1'b0, 1'b0, "b2b_3");
    idle_cycle();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_result_hold", result, 32'hFF00_FF00);
    chk("idle_zero_hold", {31'd0, zero}, 32'd0);
    idle_cycle();
    chk("idle2_result_hold", result, 32'hFF00_FF00);

    // Reset during a valid op discards it
    issue(4'b0010, 32'd3, 32'd4, 32'h0000_0007, 1'b0, 1'b0, "pre_reset_add");
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 4'b0001;
    op1      = 32'h0000_FFFF;
    op2      = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_result", result, 32'h0);
    chk("midreset_zero", {31'd0, zero}, 32'd1);
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, "post_reset_and");
    idle_cycle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_alu.md
Name:
rv_alu

Overview:
- Single-cycle-latency, registered 32-bit integer ALU for the RISC-V execute stage.
- Takes two operands and a 4-bit operation code and produces a result plus a zero flag.
- The zero flag drives branch resolution (BEQ/BNE via SUB).
- Inputs are sampled on a valid strobe; outputs are registered and held until the next accepted operation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two ≥ 8.
- SHW, log2(WIDTH) (5), number of low op2 bits used as shift amount.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operands/opcode valid this cycle; operation accepted when high.
- op1  input  WIDTH  first operand (rs1).
- op2  input  WIDTH  second operand (rs2/immediate; low SHW bits = shift amount).
- alu_op  input  4  operation select.
- result  output  WIDTH  registered operation result.
- zero  output  1  registered; 1 when result equals all-zeros.
- out_valid  output  1  registered; 1 the cycle after an accepted operation.
- illegal_op  output  1  registered; 1 when the accepted alu_op is unassigned.

Behaviour:
- Reset on rising clk with rst_n=0: result=0, zero=1, out_valid=0, illegal_op=0. Reset has priority over in_valid.
- Latency is exactly 1 cycle. Inputs are accepted at edge N when in_valid=1; result, zero and illegal_op are valid after that edge, with out_valid=1 for that one cycle.
- in_valid=0 at an edge: out_valid→0; result, zero and illegal_op hold their previous values.
- Back-to-back in_valid is supported: one result per cycle, no stall, no backpressure.
- Opcode map (binary):
  - 0000 AND: op1 & op2.
  - 0001 OR: op1 | op2.
  - 0010 ADD: op1 + op2, modulo 2^WIDTH, carry discarded.
  - 0110 SUB: op1 − op2, modulo 2^WIDTH.
  - 0100 SLT: signed two's-complement compare; result = 1 if op1 < op2, else 0, zero-extended.
  - 0111 SLTU: unsigned compare; result = 1 if op1 < op2, else 0.
  - 0101 XOR: op1 ^ op2.
  - 1000 SRL: logical right shift of op1 by op2[SHW-1:0], zero fill.
  - 1001 SLL: left shift of op1 by op2[SHW-1:0], zero fill.
  - 1010 SRA: arithmetic right shift of op1 by op2[SHW-1:0], sign fill from op1[WIDTH-1].
  - All other codes: result=0, zero=1, illegal_op=1.
- Shifts ignore op2 bits above SHW-1; a shift of 0 passes op1 unchanged. A shift of 31 on SRA of a negative value gives all-ones.
- ADD/SUB overflow is not flagged; wrap-around is silent, e.g. 7FFFFFFF+1 = 80000000.
- SLT boundary cases:
  - 80000000 vs 7FFFFFFF gives 1 (signed).
  - Same operands under SLTU give 0.
  - Equal operands give 0 for both.
- zero is computed from the registered result value for every opcode, including logic and shift ops.
- Reset asserted mid-stream discards any operation presented in that cycle; out_valid is 0 on the following cycle.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 → result=0, zero=1, out_valid=0, illegal_op=0. Release, then present ADD 20+22 → next cycle result=0x0000002A, zero=0, out_valid=1.
- Logic: op1=A5A5A5A5, op2=5A5A5A5A. AND → 00000000, zero=1. OR → FFFFFFFF, zero=0. Separately, XOR 12345678^87654321 → 95511559.
- Arithmetic/compare:
  - SUB 50−30 → 00000014.
  - SUB 5−5 → 0, zero=1.
  - SLT 10<20 → 1.
  - SLT 80000000 vs 7FFFFFFF → 1.
  - SLTU same operands → 0.
  - ADD 7FFFFFFF+1 → 80000000.
- Shifts: op1=FFFFFFFF, op2=4. SRL → 0FFFFFFF. SLL → FFFFFFF0. SRA → FFFFFFFF. Also op1=80000000, op2=0x21 (shamt=1) SRA → C0000000.
- Handshake: back-to-back valid ops in cycles 1–3 then idle → three consecutive out_valid pulses with matching results; out_valid=0 afterwards and result holds the last value.
- Illegal op: alu_op=1111 with in_valid=1 → illegal_op=1, result=0, zero=1. The next legal op clears illegal_op.
